// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and iteration count.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_DIVU  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_MULT  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } md_state_t;

  localparam int ITER_COUNT = 32;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_md_core.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, one step per cycle for ITER_COUNT cycles after start.
module md_core
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic               done,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
);

  logic               active;
  logic               div_q;
  logic [4:0]         cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   rem_q, rem_nxt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               unused_diff_bit;

  // acc holds {partial product, multiplier} for MUL and {-, dividend/quotient} for DIV
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted = {rem_q, acc[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    acc_nxt = {sum, acc[WIDTH-1:1]};
    rem_nxt = rem_q;
    if (div_q) begin
      acc_nxt = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH+1]};
      rem_nxt = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  // After a successful subtract the remainder is below the divisor, so bit WIDTH is zero.
  assign unused_diff_bit = diff[WIDTH];

  assign done = active && (cnt == 5'(ITER_COUNT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      div_q  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      rem_q  <= '0;
    end else if (start) begin
      active <= 1'b1;
      div_q  <= is_div;
      cnt    <= '0;
      opnd   <= is_div ? b_mag : a_mag;
      acc    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
      rem_q  <= '0;
    end else if (active) begin
      acc   <= acc_nxt;
      rem_q <= rem_nxt;
      cnt   <= cnt + 5'd1;
      if (done) active <= 1'b0;
    end
  end

  assign prod = acc;
  assign quot = acc[WIDTH-1:0];
  assign rem  = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// MIPS HI/LO multiply/divide unit: sign handling around md_core, FSM, HI/LO
// registers, MTHI/MTLO writes, MFHI/MFLO read mux and pipeline stall.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mdstart,
  input  logic [1:0]       mdop,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hilosrc,
  input  logic [1:0]       hilodisable,
  input  logic             hiloread,
  input  logic             hilosel,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             md_stall
);

  md_state_t          state, state_nxt;
  logic               start_ok;
  logic               op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               sign_q, sign_r, div_op, div_zero;
  logic               core_done;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   hi, lo, hi_res, lo_res;

  assign start_ok  = (state == S_IDLE) && mdstart;
  assign op_signed = is_signed_op(mdop);
  assign a_neg     = op_signed && srca[WIDTH-1];
  assign b_neg     = op_signed && srcb[WIDTH-1];
  assign a_mag     = a_neg ? -srca : srca;
  assign b_mag     = b_neg ? -srcb : srcb;

  md_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start_ok),
    .is_div  (~mdop[0]),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .done    (core_done),
    .prod    (prod),
    .quot    (quot),
    .rem     (rem)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mdstart) state_nxt = S_CALC;
      S_CALC:  if (core_done) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_op   <= 1'b0;
      div_zero <= 1'b0;
    end else if (start_ok) begin
      sign_q   <= a_neg ^ b_neg;
      sign_r   <= a_neg;
      div_op   <= ~mdop[0];
      div_zero <= (srcb == '0);
    end
  end

  // Sign-corrected remainder of a zero divide reconstructs srca exactly.
  always_comb begin
    prod_s = sign_q ? -prod : prod;
    hi_res = prod_s[2*WIDTH-1:WIDTH];
    lo_res = prod_s[WIDTH-1:0];
    if (div_op) begin
      hi_res = sign_r ? -rem : rem;
      lo_res = div_zero ? '1 : (sign_q ? -quot : quot);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      hi <= hi_res;
      lo <= lo_res;
    end else if ((state == S_IDLE) && hilosrc) begin
      if (!hilodisable[1]) hi <= srca;
      if (!hilodisable[0]) lo <= srca;
    end
  end

  assign busy     = (state != S_IDLE);
  assign hilo_out = hilosel ? hi : lo;
  assign md_stall = busy && (hiloread || mdstart || hilosrc);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected {HI,LO} per
// operation, plus stall, direct-write and reset-abort scenarios.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mdstart;
  logic [1:0]  mdop;
  logic [31:0] srca, srcb;
  logic        hilosrc;
  logic [1:0]  hilodisable;
  logic        hiloread;
  logic        hilosel;
  logic [31:0] hilo_out;
  logic        busy;
  logic        md_stall;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mdstart     (mdstart),
    .mdop        (mdop),
    .srca        (srca),
    .srcb        (srcb),
    .hilosrc     (hilosrc),
    .hilodisable (hilodisable),
    .hiloread    (hiloread),
    .hilosel     (hilosel),
    .hilo_out    (hilo_out),
    .busy        (busy),
    .md_stall    (md_stall)
  );

  always @(posedge clk)
    assert (!(reset_n && mdstart && hilosrc)) else $error("mdstart and hilosrc asserted together");

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 2000000)", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULTU: return {32'h0, a} * {32'h0, b};
      MD_MULT: begin
        p = sa * sb;
        return p;
      end
      MD_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        q = sq;
        r = sr;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge following the start edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv);
    sb_q.push_back(expv);
    mdop    = op;
    srca    = a;
    srcb    = b;
    mdstart = 1'b1;
    @(negedge clk);
    mdstart = 1'b0;
  endtask

  task automatic drain(output int cyc, output logic [31:0] hi, output logic [31:0] lo);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    hilosel = 1'b1;
    #1 hi = hilo_out;
    hilosel = 1'b0;
    #1 lo = hilo_out;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mdstart = 1'b0; mdop = 2'b00; srca = '0; srcb = '0;
    hilosrc = 1'b0; hilodisable = 2'b00; hiloread = 1'b1; hilosel = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (md_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", md_stall); end
    n_checks++;
    if (hilo_out !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hilo_out); end
    hilosel = 1'b0;
    #1;
    n_checks++;
    if (hilo_out !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", hilo_out); end
    hiloread = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  ops [7] = '{MD_MULTU, MD_MULT, MD_MULT, MD_DIV, MD_DIVU, MD_DIV, MD_DIV};
    logic [31:0] as  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                             32'd7, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] bs  [7] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd2,
                             32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [63:0] ex  [7] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1,
                             64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFD,
                             64'h0000_0007_FFFF_FFFF, 64'h0000_0000_8000_0000,
                             64'hFFFF_FFF9_FFFF_FFFF};
    int cyc;
    logic [31:0] hi, lo;
    logic [63:0] expv;
    for (int i = 0; i < 7; i++) begin
      start_op(ops[i], as[i], bs[i], ex[i]);
      drain(cyc, hi, lo);
      expv = sb_q.pop_front();
      n_checks++;
      if (cyc != 33) begin n_fail++; $display("FAIL directed%0d_busy_cycles: got %0d want 33", i, cyc); end
      n_checks++;
      if (hi !== expv[63:32]) begin n_fail++; $display("FAIL directed%0d_hi: got %h want %h", i, hi, expv[63:32]); end
      n_checks++;
      if (lo !== expv[31:0]) begin n_fail++; $display("FAIL directed%0d_lo: got %h want %h", i, lo, expv[31:0]); end
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [31:0] hi, lo, a, b;
    logic [1:0]  op;
    logic [63:0] expv;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      start_op(op, a, b, model(op, a, b));
      drain(cyc, hi, lo);
      expv = sb_q.pop_front();
      n_checks++;
      if (hi !== expv[63:32] || lo !== expv[31:0])
        begin n_fail++; $display("FAIL random%0d op=%b a=%h b=%h: got %h_%h want %h", i, op, a, b, hi, lo, expv); end
    end
  endtask

  task automatic test_back_to_back();
    int stall_cnt, cyc;
    logic [31:0] hi, lo;
    logic [63:0] e1, e2;
    start_op(MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    hiloread = 1'b1;
    hilosel  = 1'b0;
    mdop     = MD_MULTU;
    srca     = 32'h0001_0000;
    srcb     = 32'h0001_0000;
    sb_q.push_back(64'h0000_0001_0000_0000);
    mdstart  = 1'b1;
    stall_cnt = 0;
    while (md_stall === 1'b1 && stall_cnt < 100) begin
      stall_cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (stall_cnt != 33) begin n_fail++; $display("FAIL stall_cycles: got %0d want 33", stall_cnt); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_gap_busy: got %b want 0", busy); end
    e1 = sb_q.pop_front();
    #1;
    n_checks++;
    if (hilo_out !== e1[31:0]) begin n_fail++; $display("FAIL mflo_after_stall: got %h want %h", hilo_out, e1[31:0]); end
    hilosel = 1'b1;
    #1;
    n_checks++;
    if (hilo_out !== e1[63:32]) begin n_fail++; $display("FAIL mfhi_after_stall: got %h want %h", hilo_out, e1[63:32]); end
    @(negedge clk);
    mdstart  = 1'b0;
    hiloread = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL held_start_e34: busy got %b want 1", busy); end
    drain(cyc, hi, lo);
    e2 = sb_q.pop_front();
    n_checks++;
    if (cyc != 33) begin n_fail++; $display("FAIL second_busy_cycles: got %0d want 33", cyc); end
    n_checks++;
    if (hi !== e2[63:32] || lo !== e2[31:0])
      begin n_fail++; $display("FAIL second_result: got %h_%h want %h", hi, lo, e2); end
  endtask

  task automatic test_direct_write();
    @(negedge clk);
    hilosrc = 1'b1; hilodisable = 2'b00; srca = 32'h1111_1111;
    @(negedge clk);
    srca = 32'hAAAA_5555; hilodisable = 2'b10; hilosel = 1'b0;
    #1;
    n_checks++;
    if (hilo_out !== 32'h1111_1111) begin n_fail++; $display("FAIL mtlo_same_cycle_read: got %h want 11111111", hilo_out); end
    @(negedge clk);
    hilosrc = 1'b0;
    #1;
    n_checks++;
    if (hilo_out !== 32'hAAAA_5555) begin n_fail++; $display("FAIL mtlo_lo: got %h want aaaa5555", hilo_out); end
    hilosel = 1'b1;
    #1;
    n_checks++;
    if (hilo_out !== 32'h1111_1111) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h want 11111111", hilo_out); end
    hilosrc = 1'b1; hilodisable = 2'b01; srca = 32'h1234_5678;
    @(negedge clk);
    hilosrc = 1'b0;
    #1;
    n_checks++;
    if (hilo_out !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi: got %h want 12345678", hilo_out); end
    hilosel = 1'b0;
    #1;
    n_checks++;
    if (hilo_out !== 32'hAAAA_5555) begin n_fail++; $display("FAIL mthi_lo_kept: got %h want aaaa5555", hilo_out); end
    hilosrc = 1'b1; hilodisable = 2'b11; srca = 32'hDEAD_BEEF;
    @(negedge clk);
    hilosrc = 1'b0;
    #1;
    n_checks++;
    if (hilo_out !== 32'hAAAA_5555) begin n_fail++; $display("FAIL inhibit_lo: got %h want aaaa5555", hilo_out); end
    hilosel = 1'b1;
    #1;
    n_checks++;
    if (hilo_out !== 32'h1234_5678) begin n_fail++; $display("FAIL inhibit_hi: got %h want 12345678", hilo_out); end
    hilodisable = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int cyc;
    logic [31:0] hi, lo;
    logic [63:0] expv;
    mdop = MD_DIV; srca = 32'd1000; srcb = 32'd7; mdstart = 1'b1;
    @(negedge clk);
    mdstart = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midop_busy: got %b want 1", busy); end
    reset_n = 1'b0;
    hilosel = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++;
    if (hilo_out !== 32'h0) begin n_fail++; $display("FAIL abort_hi: got %h want 0", hilo_out); end
    hilosel = 1'b0;
    #1;
    n_checks++;
    if (hilo_out !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h want 0", hilo_out); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_op(MD_MULTU, 32'd6, 32'd7, 64'd42);
    drain(cyc, hi, lo);
    expv = sb_q.pop_front();
    n_checks++;
    if (hi !== expv[63:32] || lo !== expv[31:0])
      begin n_fail++; $display("FAIL post_reset_multu: got %h_%h want %h", hi, lo, expv); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_direct_write();
    test_reset_midop();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d want 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
